// File: rtl/not_unit_arbiter.sv
// not_unit_arbiter: round-robin shared registered bitwise-inverter lane for NUM_REQ requesters
//   clk, rst_n (sync, active-low); req_valid/req_data/req_ready per requester;
//   rsp_valid/rsp_data/rsp_id/rsp_ready single response port; grant_count accept counter
//   (counts only with NOT_ARB_STATS_EN defined, otherwise tied to zero).
module not_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  input  logic                     rsp_ready,
  output logic [15:0]              grant_count
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_d;
  logic [ID_W-1:0] ptr, g;
  logic [ID_W:0] idx;
  logic found, accept;
  logic [NUM_REQ-1:0] gnt;
  always_comb begin
    g = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      idx = (idx >= (ID_W+1)'(NUM_REQ)) ? idx - (ID_W+1)'(NUM_REQ) : idx;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        g = idx[ID_W-1:0];
      end
    end
    gnt = found ? (NUM_REQ'(1) << g) : '0;
  end
  // no grant is offered while reset is held, so nothing looks accepted during reset
  assign accept = rst_n && (state == IDLE) && found;
  assign req_ready = accept ? gnt : '0;
  assign rsp_valid = (state == RESP);
  always_comb begin
    state_d = (state == IDLE) ? (accept ? RESP : IDLE) : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    state <= rst_n ? state_d : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      rsp_data <= '0;
      rsp_id <= '0;
    end else if (accept) begin
      ptr <= (g == ID_W'(NUM_REQ-1)) ? '0 : g + 1'b1;
      rsp_data <= ~req_data[int'(g)*WIDTH +: WIDTH];
      rsp_id <= g;
    end
  end
`ifdef NOT_ARB_STATS_EN
  logic [15:0] grant_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) grant_cnt <= '0;
    else if (accept && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
  end
  assign grant_count = grant_cnt;
`else
  assign grant_count = 16'h0000;
`endif
endmodule

// File: tb/tb_not_unit_arbiter.sv
// tb_not_unit_arbiter: directed and randomized checks of not_unit_arbiter against a behavioural model
module tb_not_unit_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid;
  logic [31:0] req_data;
  logic [3:0] req_ready;
  logic rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_id;
  logic rsp_ready;
  logic [15:0] grant_count;
  int total = 0;
  int bad = 0;

  not_unit_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_data = 32'h13121110;
    rsp_ready = 1'b1;
    cyc();
    cyc();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rsp_data); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    total++; if (grant_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%h exp=0000", grant_count); end
    rst_n = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_data = 32'h00A50000;
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    cyc();
    req_valid = '0;
    #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_data !== 8'h5A) begin bad++; $display("FAIL single_data got=%h exp=5a", rsp_data); end
    total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL single_id got=%0d exp=2", rsp_id); end
    cyc();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_drop got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d;
    do_reset();
    req_valid = 4'b1111;
    req_data = 32'h13121110;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      total++; if (req_ready !== 4'(1 << order[n])) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%0d", n, req_ready, order[n]); end
      cyc();
      exp_d = ~(8'h10 + 8'(order[n]));
      total++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 2'(order[n])) begin
        bad++; $display("FAIL rr_rsp%0d got=%b/%h/%0d exp=1/%h/%0d", n, rsp_valid, rsp_data, rsp_id, exp_d, order[n]);
      end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_busy%0d got=%b exp=0000", n, req_ready); end
      cyc();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0010;
    req_data = 32'h55550055;
    rsp_ready = 1'b0;
    cyc();
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h/%0d/%b exp=1/ff/1/0000", n, rsp_valid, rsp_data, rsp_id, req_ready);
      end
      cyc();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    cyc();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", rsp_valid); end
    cyc();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_resp();
    do_reset();
    req_valid = 4'b0100;
    req_data = 32'h00330000;
    rsp_ready = 1'b0;
    cyc();
    req_valid = '0;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_pend got=%b exp=1", rsp_valid); end
    rst_n = 1'b0;
    cyc();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", rsp_valid); end
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_resp_ptr got=%b exp=0001", req_ready); end
    req_valid = '0;
    cyc();
  endtask

  task automatic accepts(input int n);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    repeat (n) begin
      cyc();
      cyc();
    end
    req_valid = '0;
  endtask

  task automatic test_stats();
    do_reset();
`ifdef NOT_ARB_STATS_EN
    accepts(7);
    total++; if (grant_count !== 16'd7) begin bad++; $display("FAIL stats_count got=%0d exp=7", grant_count); end
    force dut.grant_cnt = 16'hFFFE;
    #1;
    release dut.grant_cnt;
    accepts(3);
    total++; if (grant_count !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got=%h exp=ffff", grant_count); end
`else
    accepts(7);
    total++; if (grant_count !== 16'h0) begin bad++; $display("FAIL stats_off got=%h exp=0000", grant_count); end
`endif
  endtask

  task automatic test_random();
    int m_ptr = 0, win;
    bit m_pend = 0;
    logic [7:0] m_data = 0;
    int m_id = 0;
    int m_cnt = 0;
    logic [3:0] exp_rdy;
    logic [7:0] d[4];
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        d[i] = 8'($urandom);
        req_data[i*8 +: 8] = d[i];
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      win = -1;
      if (!m_pend && rst_n)
        for (int k = 0; k < 4; k++)
          if (win < 0 && req_valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      exp_rdy = (win < 0) ? 4'b0 : 4'(1 << win);
      total++; if (req_ready !== exp_rdy || rsp_valid !== m_pend || rsp_data !== m_data || rsp_id !== 2'(m_id)) begin
        bad++; $display("FAIL rand%0d got=%b/%b/%h/%0d exp=%b/%b/%h/%0d", n, req_ready, rsp_valid, rsp_data, rsp_id, exp_rdy, m_pend, m_data, m_id);
      end
`ifdef NOT_ARB_STATS_EN
      total++; if (grant_count !== 16'(m_cnt)) begin bad++; $display("FAIL rand_cnt%0d got=%0d exp=%0d", n, grant_count, m_cnt); end
`else
      total++; if (grant_count !== 16'h0) begin bad++; $display("FAIL rand_cnt%0d got=%0d exp=0", n, grant_count); end
`endif
      if (!rst_n) begin
        m_pend = 0; m_ptr = 0; m_data = 0; m_id = 0; m_cnt = 0;
      end else if (win >= 0) begin
        m_pend = 1; m_data = ~d[win]; m_id = win; m_ptr = (win + 1) % 4; m_cnt++;
      end else if (m_pend && rsp_ready) begin
        m_pend = 0;
      end
      cyc();
    end
    rst_n = 1'b1;
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_resp();
    test_stats();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
